// File: rtl/uart_pkg.sv
// Shared timing helpers and FSM encodings for the 8N1 UART transmitter and receiver.
package uart_pkg;

  localparam int FRAME_BITS = 10;

  // Clock cycles per serial symbol, rounded to the nearest integer.
  function automatic int symbolTime(input int clockFreq, input int baudRate);
    return (clockFreq + baudRate / 2) / baudRate;
  endfunction

  function automatic int sampleTime(input int clockFreq, input int baudRate);
    return symbolTime(clockFreq, baudRate) / 2;
  endfunction

  typedef enum logic {
    TX_IDLE,
    TX_SHIFT
  } txState_t;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rxState_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 deserializer: synchronizes sIn, samples each bit at mid-symbol and holds the byte until consumed.
module uart_rx
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sIn,
  output logic [7:0] dataOut,
  output logic       dataOutValid,
  input  logic       dataOutReady,
  output rxState_t   state
);

  localparam int SymbolEdgeTime = symbolTime(ClockFreq, BaudRate);
  localparam int SampleTime = sampleTime(ClockFreq, BaudRate);
  localparam int CntW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CntW-1:0] SymLast = CntW'(SymbolEdgeTime - 1);
  localparam logic [CntW-1:0] SampleFirst = CntW'((SampleTime > 0) ? SampleTime - 1 : 0);
  localparam logic [3:0] StopIdx = 4'(FRAME_BITS - 1);

  logic [1:0] syncReg;
  logic       sInSync;
  logic [CntW-1:0] clkCnt;
  logic [3:0]      bitCnt;
  logic [7:0]      dataShift;

  assign sInSync = syncReg[1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) syncReg <= 2'b11;
    else        syncReg <= {syncReg[0], sIn};
  end

  // Handshake: dataOut is taken on a rising edge with dataOutValid && dataOutReady.
  // The clear is written first so a byte completing in the same cycle keeps valid high.
  // clkCnt counts down to the next sampling point; zero means "sample now".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RX_IDLE;
      clkCnt       <= '0;
      bitCnt       <= '0;
      dataShift    <= '0;
      dataOut      <= '0;
      dataOutValid <= 1'b0;
    end else begin
      if (dataOutReady) dataOutValid <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!sInSync) begin
            clkCnt <= SampleFirst;
            bitCnt <= '0;
            state  <= RX_RECV;
          end
        end
        RX_RECV: begin
          if (clkCnt == '0) begin
            clkCnt <= SymLast;
            bitCnt <= bitCnt + 4'd1;
            if (bitCnt == '0) begin
              if (sInSync) state <= RX_IDLE;
            end else if (bitCnt == StopIdx) begin
              // Leave at mid-stop so the next start edge is caught even with rate skew.
              state <= RX_IDLE;
              if (sInSync) begin
                dataOut      <= dataShift;
                dataOutValid <= 1'b1;
              end
            end else begin
              dataShift <= {sInSync, dataShift[7:1]};
            end
          end else begin
            clkCnt <= clkCnt - CntW'(1);
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serializer: accepts one byte per handshake and shifts a {stop, data, start} frame onto sOut.
module uart_tx
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] dataIn,
  input  logic       dataInValid,
  output logic       dataInReady,
  output logic       sOut,
  output txState_t   state
);

  localparam int SymbolEdgeTime = symbolTime(ClockFreq, BaudRate);
  localparam int CntW = (SymbolEdgeTime > 1) ? $clog2(SymbolEdgeTime) : 1;
  localparam logic [CntW-1:0] SymLast = CntW'(SymbolEdgeTime - 1);
  localparam logic [FRAME_BITS-1:0] StopOnly = FRAME_BITS'(1);

  logic [FRAME_BITS-1:0] shiftReg;
  logic [CntW-1:0]       clkCnt;

  // Handshake: a byte moves when dataInValid && dataInReady on a rising edge;
  // dataInReady stays low from the next cycle until the stop bit has fully elapsed.
  // shiftReg[0] is always the bit currently on the line; zeros shift in behind,
  // so a value of 1 means the stop bit is the one being sent.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= TX_IDLE;
      shiftReg    <= '1;
      clkCnt      <= '0;
      sOut        <= 1'b1;
      dataInReady <= 1'b1;
    end else begin
      case (state)
        TX_IDLE: begin
          if (dataInValid && dataInReady) begin
            shiftReg    <= {1'b1, dataIn, 1'b0};
            sOut        <= 1'b0;
            clkCnt      <= '0;
            dataInReady <= 1'b0;
            state       <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          if (clkCnt == SymLast) begin
            clkCnt <= '0;
            if (shiftReg == StopOnly) begin
              sOut        <= 1'b1;
              dataInReady <= 1'b1;
              state       <= TX_IDLE;
            end else begin
              shiftReg <= {1'b0, shiftReg[FRAME_BITS-1:1]};
              sOut     <= shiftReg[1];
            end
          end else begin
            clkCnt <= clkCnt + CntW'(1);
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART: independent transmitter and receiver sharing only clock and reset.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int ClockFreq = 50_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SIn,
  output logic       SOut,
  output txState_t   TxState,
  output rxState_t   RxState
);

  uart_tx #(
    .ClockFreq(ClockFreq),
    .BaudRate (BaudRate)
  ) txInst (
    .clock      (Clock),
    .reset      (Reset),
    .dataIn     (DataIn),
    .dataInValid(DataInValid),
    .dataInReady(DataInReady),
    .sOut       (SOut),
    .state      (TxState)
  );

  uart_rx #(
    .ClockFreq(ClockFreq),
    .BaudRate (BaudRate)
  ) rxInst (
    .clock       (Clock),
    .reset       (Reset),
    .sIn         (SIn),
    .dataOut     (DataOut),
    .dataOutValid(DataOutValid),
    .dataOutReady(DataOutReady),
    .state       (RxState)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at 460800 baud (109-cycle symbols) to keep frames short.
module tb_uart_transceiver;
  import uart_pkg::*;

  localparam int CLOCK_FREQ = 50_000_000;
  localparam int BAUD_RATE  = 460_800;
  localparam int SYM   = 109;  // 50e6 / 460800 = 108.51, rounded to nearest
  localparam int HALF  = 54;
  localparam int FRAME = 10 * SYM;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       data_in_valid = 1'b0;
  logic       data_in_ready;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready = 1'b0;
  logic       s_out;
  logic       s_in;
  logic       loopback = 1'b1;
  logic       s_in_drv = 1'b1;
  txState_t   tx_state;
  rxState_t   rx_state;

  int num_checks = 0;
  int num_errors = 0;
  logic [7:0] exp_q[$];

  assign s_in = loopback ? s_out : s_in_drv;

  // ---------------- clock / reset / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #(80_000 * 10);
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  uart_transceiver #(
    .ClockFreq(CLOCK_FREQ),
    .BaudRate (BAUD_RATE)
  ) dut (
    .Clock       (clk),
    .Reset       (rst_n),
    .DataIn      (data_in),
    .DataInValid (data_in_valid),
    .DataInReady (data_in_ready),
    .DataOut     (data_out),
    .DataOutValid(data_out_valid),
    .DataOutReady(data_out_ready),
    .SIn         (s_in),
    .SOut        (s_out),
    .TxState     (tx_state),
    .RxState     (rx_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input string tag, input int budget);
    int n = 0;
    while (!data_in_ready && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (!data_in_ready) check({tag, "_ready_timeout"}, data_in_ready, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!data_out_valid && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
    if (!data_out_valid) check({tag, "_valid_timeout"}, data_out_valid, 1);
  endtask

  // Returns at the negedge right after the accepting rising edge.
  task automatic send_byte(input logic [7:0] b);
    wait_ready("send", 3 * FRAME);
    data_in = b;
    data_in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    data_in_valid = 1'b0;
  endtask

  task automatic consume();
    data_out_ready = 1'b1;
    @(negedge clk);
    data_out_ready = 1'b0;
  endtask

  task automatic recv_check(input string tag);
    int cyc;
    logic [7:0] exp;
    wait_valid(tag, 3 * FRAME, cyc);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, data_out_valid, 0);
    end else begin
      exp = exp_q.pop_front();
      check({tag, "_data"}, data_out, exp);
    end
  endtask

  // Drives a frame on s_in_drv; a bad stop is held low only past its mid-point.
  task automatic drive_frame(input logic [7:0] b, input logic good_stop);
    s_in_drv = 1'b0;
    repeat (SYM) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      s_in_drv = b[i];
      repeat (SYM) @(negedge clk);
    end
    if (good_stop) begin
      s_in_drv = 1'b1;
      repeat (SYM) @(negedge clk);
    end else begin
      s_in_drv = 1'b0;
      repeat (HALF + 20) @(negedge clk);
      s_in_drv = 1'b1;
    end
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] echo_seq [10] = '{8'd13, 8'd10, 8'd13, 8'd10, 8'd13, 8'd10, 8'd13, 8'd10, 8'd62, 8'd32};

  initial begin
    int t;
    int cyc;
    logic [9:0] frame;
    logic [9:0] exp_frame;

    // 1: reset values during and after reset
    rst_n = 1'b0;
    repeat (15) @(negedge clk);
    check("rst_sout", s_out, 1);
    check("rst_ready", data_in_ready, 1);
    check("rst_valid", data_out_valid, 0);
    check("rst_dataout", data_out, 8'h00);
    repeat (15) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_sout", s_out, 1);
    check("post_rst_ready", data_in_ready, 1);
    check("post_rst_valid", data_out_valid, 0);
    check("post_rst_tx_idle", tx_state, TX_IDLE);

    // 2: loopback 8'h7a, bit-level frame check and timing
    loopback = 1'b1;
    exp_q.push_back(8'h7a);
    send_byte(8'h7a);
    t = 0;
    check("accept_ready_drop", data_in_ready, 0);
    check("accept_start_bit", s_out, 0);
    // A byte offered while busy must be ignored.
    data_in = 8'h11;
    data_in_valid = 1'b1;
    repeat (5) begin @(negedge clk); t++; end
    data_in_valid = 1'b0;
    exp_frame = {1'b1, 8'h7a, 1'b0};
    frame = '0;
    for (int k = 0; k < 10; k++) begin
      while (t < k * SYM + HALF) begin @(negedge clk); t++; end
      frame[k] = s_out;
    end
    check("tx_frame_bits", frame, exp_frame);
    while (!data_out_valid && t < 2 * FRAME) begin @(negedge clk); t++; end
    check("rx_latency_in_window", (t >= FRAME - SYM) && (t <= FRAME), 1);
    check("loop_7a_data", data_out, exp_q.pop_front());
    while (!data_in_ready && t < 2 * FRAME) begin @(negedge clk); t++; end
    check("tx_ready_after_frame", t, FRAME);
    consume();
    check("valid_clear_7a", data_out_valid, 0);
    repeat (FRAME + SYM) @(negedge clk);
    check("busy_byte_ignored", data_out_valid, 0);

    // 3: back-to-back 0x0d, 0x0a with 1-cycle consume pulses
    exp_q.push_back(8'h0d);
    send_byte(8'h0d);
    recv_check("b2b_0d");
    consume();
    check("b2b_0d_clear", data_out_valid, 0);
    exp_q.push_back(8'h0a);
    send_byte(8'h0a);
    recv_check("b2b_0a");
    consume();
    check("b2b_0a_clear", data_out_valid, 0);

    // 4: echo sequence consumed after a 30-cycle delay
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          exp_q.push_back(echo_seq[i]);
          send_byte(echo_seq[i]);
        end
      end
      begin
        for (int i = 0; i < 10; i++) begin
          wait_valid("echo", 3 * FRAME, cyc);
          repeat (30) @(negedge clk);
          if (exp_q.size() == 0) check("echo_queue_empty", data_out_valid, 0);
          else check($sformatf("echo_%0d", i), data_out, exp_q.pop_front());
          consume();
        end
      end
    join
    check("echo_all_received", exp_q.size(), 0);
    check("echo_valid_clear", data_out_valid, 0);

    // 5: overrun, then a framing error and a good hand-driven frame
    send_byte(8'h3e);
    send_byte(8'h20);
    wait_ready("overrun", 3 * FRAME);
    check("overrun_valid", data_out_valid, 1);
    check("overrun_data", data_out, 8'h20);
    consume();
    check("overrun_clear", data_out_valid, 0);
    repeat (SYM) @(negedge clk);
    loopback = 1'b0;
    s_in_drv = 1'b1;
    repeat (SYM) @(negedge clk);
    drive_frame(8'h55, 1'b0);
    repeat (3 * SYM) @(negedge clk);
    check("framing_no_valid", data_out_valid, 0);
    check("framing_data_kept", data_out, 8'h20);
    check("framing_rx_idle", rx_state, RX_IDLE);
    drive_frame(8'hc3, 1'b1);
    repeat (SYM) @(negedge clk);
    check("manual_valid", data_out_valid, 1);
    check("manual_data", data_out, 8'hc3);
    consume();

    // 6: reset mid-TX frame, then a short low glitch on SIn
    loopback = 1'b1;
    send_byte(8'h00);
    repeat (300) @(negedge clk);
    check("midframe_sout_low", s_out, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_sout", s_out, 1);
    check("midrst_ready", data_in_ready, 1);
    check("midrst_valid", data_out_valid, 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * FRAME) @(negedge clk);
    check("after_midrst_no_byte", data_out_valid, 0);
    check("after_midrst_sout", s_out, 1);
    loopback = 1'b0;
    s_in_drv = 1'b0;
    repeat (SYM / 3) @(negedge clk);
    s_in_drv = 1'b1;
    repeat (2 * SYM) @(negedge clk);
    check("glitch_no_valid", data_out_valid, 0);
    check("glitch_rx_idle", rx_state, RX_IDLE);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
